// File: rtl/top_mem_inst.sv
// Instruction memory with a clock-manager style lock generator gating all accesses.
// Optional macro TOP_MEM_INST_WR_FWD_EN: same-edge same-address read returns the new write data.
module top_mem_inst #(
  parameter int NB_DATA     = 32,
  parameter int ADDRWIDTH   = 7,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 reset_wz_i,
  input  logic [NB_DATA-1:0]   inst_load_i,
  input  logic [ADDRWIDTH-1:0] wr_addr_i,
  input  logic                 en_read_i,
  input  logic                 en_write_i,
  output logic [NB_DATA-1:0]   instruction_o,
  output logic                 locked_o
);

  localparam int         DEPTH    = 1 << ADDRWIDTH;
  localparam logic [7:0] LOCK_VAL = 8'(LOCK_CYCLES);

  logic [7:0]         lock_cnt_q, lock_cnt_d;
  logic               locked_q, locked_d;
  logic [NB_DATA-1:0] instruction_q, instruction_d;
  logic [NB_DATA-1:0] rd_word;
  logic               wr_en, rd_en;

  logic [NB_DATA-1:0] mem [DEPTH];

  // Counting with '<' keeps the counter saturating even from an arbitrary power-up value.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (reset_wz_i) begin
      lock_cnt_d = 8'd0;
    end else if (lock_cnt_q < LOCK_VAL) begin
      lock_cnt_d = lock_cnt_q + 8'd1;
    end else begin
      lock_cnt_d = LOCK_VAL;
    end
    locked_d = !reset_wz_i && (lock_cnt_d == LOCK_VAL);
  end

  assign wr_en = locked_q && !reset_i && en_write_i;
  assign rd_en = locked_q && !reset_i && en_read_i;

`ifdef TOP_MEM_INST_WR_FWD_EN
  assign rd_word = wr_en ? inst_load_i : mem[wr_addr_i];
`else
  assign rd_word = mem[wr_addr_i];
`endif

  always_comb begin
    instruction_d = instruction_q;
    if (reset_i) begin
      instruction_d = '0;
    end else if (rd_en) begin
      instruction_d = rd_word;
    end
  end

  always_ff @(posedge clock_i) begin
    lock_cnt_q    <= lock_cnt_d;
    locked_q      <= locked_d;
    instruction_q <= instruction_d;
  end

  // Memory has no reset so it maps onto block RAM; contents survive both resets.
  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      mem[wr_addr_i] <= inst_load_i;
    end
  end

  assign instruction_o = instruction_q;
  assign locked_o      = locked_q;

endmodule

// File: tb/tb_top_mem_inst.sv
// Scoreboard bench for top_mem_inst: directed scenarios plus random traffic against a reference model.
module tb_top_mem_inst;

  localparam int NB_DATA     = 32;
  localparam int ADDRWIDTH   = 7;
  localparam int LOCK_CYCLES = 16;

  logic                 clock_i = 1'b0;
  logic                 reset_i = 1'b0;
  logic                 reset_wz_i = 1'b0;
  logic [NB_DATA-1:0]   inst_load_i = '0;
  logic [ADDRWIDTH-1:0] wr_addr_i = '0;
  logic                 en_read_i = 1'b0;
  logic                 en_write_i = 1'b0;
  logic [NB_DATA-1:0]   instruction_o;
  logic                 locked_o;

  top_mem_inst #(
    .NB_DATA(NB_DATA), .ADDRWIDTH(ADDRWIDTH), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i), .reset_wz_i(reset_wz_i),
    .inst_load_i(inst_load_i), .wr_addr_i(wr_addr_i),
    .en_read_i(en_read_i), .en_write_i(en_write_i),
    .instruction_o(instruction_o), .locked_o(locked_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [NB_DATA-1:0] ins;
    bit                 lk;
    string              tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: word store, a count of edges since the clock-manager reset, last output.
  logic [NB_DATA-1:0] mem_m [int];
  int                 edges_low = 0;
  bit                 lock_m = 1'b0;
  logic [NB_DATA-1:0] out_m = '0;

  task automatic cyc(input bit rst, input bit wz, input bit we, input bit re,
                     input logic [ADDRWIDTH-1:0] a, input logic [NB_DATA-1:0] d,
                     input string tag);
    bit   wr, rd;
    exp_t e;
    reset_i     = rst;
    reset_wz_i  = wz;
    en_write_i  = we;
    en_read_i   = re;
    wr_addr_i   = a;
    inst_load_i = d;
    @(posedge clock_i);
    wr = lock_m && !rst && we;
    rd = lock_m && !rst && re;
    if (rst) begin
      out_m = '0;
    end else if (rd) begin
`ifdef TOP_MEM_INST_WR_FWD_EN
      out_m = wr ? d : mem_m[int'(a)];
`else
      out_m = mem_m[int'(a)];
`endif
    end
    if (wr) mem_m[int'(a)] = d;
    edges_low = wz ? 0 : edges_low + 1;
    lock_m    = (edges_low >= LOCK_CYCLES);
    e.ins = out_m;
    e.lk  = lock_m;
    e.tag = tag;
    exp_q.push_back(e);
    #1;
    reset_i    = 1'b0;
    reset_wz_i = 1'b0;
    en_write_i = 1'b0;
    en_read_i  = 1'b0;
  endtask

  // Monitor: every negedge the DUT presents a settled output; compare it to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (instruction_o !== e.ins) begin
          bad++;
          $display("FAIL %s instruction_o: got %h want %h", e.tag, instruction_o, e.ins);
        end
        total++;
        if (locked_o !== e.lk) begin
          bad++;
          $display("FAIL %s locked_o: got %b want %b", e.tag, locked_o, e.lk);
        end
        $display("txn %-10s ins=%h lk=%b", e.tag, instruction_o, locked_o);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "timeout");
  end

  int written[$];

  initial begin
    bit                   we, re, rst;
    logic [ADDRWIDTH-1:0] a;
    logic [NB_DATA-1:0]   d;

    cyc(1, 1, 0, 0, 0, 0, "reset");
    cyc(1, 1, 0, 0, 0, 0, "reset");
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0, "lock_wait");
    cyc(1, 0, 0, 0, 0, 0, "rst_pulse");

    cyc(0, 0, 1, 0, 0, 32'h20080005, "wr0");
    cyc(0, 0, 1, 0, 1, 32'h2009000A, "wr1");
    cyc(0, 0, 1, 0, 2, 32'h01095020, "wr2");
    cyc(0, 0, 1, 0, 3, 32'h11111111, "wr3");
    cyc(0, 0, 1, 0, 5, 32'h12345678, "wr5");
    cyc(0, 0, 0, 1, 0, 0, "rd0");
    cyc(0, 0, 0, 1, 1, 0, "rd1");
    cyc(0, 0, 0, 1, 2, 0, "rd2");
    cyc(0, 0, 0, 0, 2, 0, "hold");
    cyc(1, 0, 0, 0, 0, 0, "rst_out");
    cyc(0, 0, 0, 1, 2, 0, "rd2_again");

    cyc(0, 0, 1, 1, 3, 32'h22222222, "rw_same");
    cyc(0, 0, 0, 1, 3, 0, "rd3_after");
    cyc(0, 0, 1, 0, 4, 32'hCAFEF00D, "wr4_a");
    cyc(0, 0, 1, 0, 4, 32'hCAFEF00D, "wr4_b");
    cyc(0, 0, 0, 1, 4, 0, "rd4");
    cyc(1, 0, 1, 0, 6, 32'hBAD00006, "rst_blocks");
    cyc(0, 0, 1, 0, 6, 32'h00000006, "wr6");
    cyc(0, 0, 0, 1, 6, 0, "rd6");

    // Clock-manager reset mid-write; later writes and reads must be ignored until relock.
    cyc(0, 1, 1, 0, 5, 32'h12345678, "wz_write");
    for (int i = 0; i < LOCK_CYCLES + 2; i++)
      cyc(0, 0, 1, (i % 3) == 0, 5, 32'hDEADBEEF, "unlocked_wr");
    cyc(0, 0, 0, 1, 5, 0, "rd5");

    cyc(1, 1, 0, 1, 0, 0, "both_rst");
    for (int i = 0; i < LOCK_CYCLES; i++) cyc(0, 0, 0, 0, 0, 0, "relock");

    for (int k = 0; k < 8; k++) written.push_back(k);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 31) == 0);
      we  = $urandom_range(0, 1);
      re  = $urandom_range(0, 1);
      d   = $urandom;
      if (re) a = ADDRWIDTH'(written[$urandom_range(0, written.size() - 1)]);
      else    a = ADDRWIDTH'($urandom_range(0, (1 << ADDRWIDTH) - 1));
      if (we && !rst) written.push_back(int'(a));
      cyc(rst, 0, we, re, a, d, "random");
    end

    repeat (3) @(negedge clock_i);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
